button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder.sv | 183 ++++++++++++++++++
 tb/tb_button_event_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns a debounced button level into single-cycle press, release, long-press
// and auto-repeat events, plus an optional double-click event.
//
// Optional feature macro: DOUBLE_CLICK_EN
//   defined   -> GAP state, double-click flag and o_double logic present
//   undefined -> release always returns to IDLE, o_double tied to 0
//
// Ports:
//   i_clk      clock, all logic on the rising edge
//   i_rst      synchronous active-high reset
//   i_btn      debounced button level, synchronous to i_clk
//   o_press    one-cycle pulse on press
//   o_release  one-cycle pulse on release
//   o_long     one-cycle pulse when the hold reaches LONG_TICKS
//   o_repeat   one-cycle pulse every REPEAT_TICKS while long-held
//   o_double   one-cycle pulse on the second press of a double-click
//   o_held     high while the button is considered held (PRESSED or LONG)
module button_event_decoder #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 250,
  parameter int unsigned DOUBLE_TICKS = 300,
  parameter logic        ACTIVE_LEVEL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_double,
  output logic o_held
);

  // Elaboration-time sanity check of the tick parameters.
  if (LONG_TICKS < 1 || REPEAT_TICKS < 1 || DOUBLE_TICKS < 1 ||
      64'(LONG_TICKS)   > (64'd1 << CNT_WIDTH) ||
      64'(REPEAT_TICKS) > (64'd1 << CNT_WIDTH) ||
      64'(DOUBLE_TICKS) > (64'd1 << CNT_WIDTH)) begin : g_bad_params
    $error("button_event_decoder: tick parameters must be in 1 .. 2**CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);

`ifdef DOUBLE_CLICK_EN
  localparam logic [CNT_WIDTH-1:0] DOUBLE_LAST = CNT_WIDTH'(DOUBLE_TICKS - 1);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_d, release_d, long_d, rpt_d;
  logic                 active;

`ifdef DOUBLE_CLICK_EN
  logic dbl_q, dbl_d;
  logic double_d;
`endif

  assign active = (i_btn == ACTIVE_LEVEL);

  // Next-state, counter and event decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    rpt_d     = 1'b0;
`ifdef DOUBLE_CLICK_EN
    dbl_d     = dbl_q;
    double_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (active) begin
          if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          release_d = 1'b1;
          cnt_d     = '0;
`ifdef DOUBLE_CLICK_EN
          // A release that ends a double-click press does not re-arm the window.
          state_d   = dbl_q ? IDLE : GAP;
`else
          state_d   = IDLE;
`endif
        end
      end
      LONG: begin
        // Release wins over a coinciding repeat boundary.
        if (active) begin
          if (cnt_q == REPEAT_LAST) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
`ifdef DOUBLE_CLICK_EN
      GAP: begin
        if (active) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          press_d  = 1'b1;
          double_d = 1'b1;
          dbl_d    = 1'b1;
        end else if (cnt_q == DOUBLE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef DOUBLE_CLICK_EN
    if (state_d == IDLE) begin
      dbl_d = 1'b0;
    end
`endif
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      o_held    <= 1'b0;
`ifdef DOUBLE_CLICK_EN
      dbl_q     <= 1'b0;
      o_double  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_press   <= press_d;
      o_release <= release_d;
      o_long    <= long_d;
      o_repeat  <= rpt_d;
      o_held    <= (state_d == PRESSED) || (state_d == LONG);
`ifdef DOUBLE_CLICK_EN
      dbl_q     <= dbl_d;
      o_double  <= double_d;
`endif
    end
  end

`ifndef DOUBLE_CLICK_EN
  assign o_double = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, REPEAT=4, DOUBLE=6.
// Expected event vectors are {press, release, long, repeat, double, held}.
module tb_button_event_decoder;

`ifdef DOUBLE_CLICK_EN
  localparam logic DBL_EN = 1'b1;
`else
  localparam logic DBL_EN = 1'b0;
`endif

  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_HELD  = 6'b000001;
  localparam logic [5:0] E_PRESS = 6'b100001;
  localparam logic [5:0] E_REL   = 6'b010000;
  localparam logic [5:0] E_LONG  = 6'b001001;
  localparam logic [5:0] E_REP   = 6'b000101;
  localparam logic [5:0] E_DBL   = {4'b1000, DBL_EN, 1'b1};

  logic clk = 1'b0;
  logic i_rst, i_btn;
  logic o_press, o_release, o_long, o_repeat, o_double, o_held;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .CNT_WIDTH    (16),
    .LONG_TICKS   (8),
    .REPEAT_TICKS (4),
    .DOUBLE_TICKS (6),
    .ACTIVE_LEVEL (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_btn     (i_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long),
    .o_repeat  (o_repeat),
    .o_double  (o_double),
    .o_held    (o_held)
  );

  // Drive inputs for one edge, then check the outputs that edge produced.
  task automatic tick(input logic btn, input logic rst, input logic [5:0] exp,
                      input string tag);
    logic [5:0] obs;
    @(negedge clk);
    i_btn = btn;
    i_rst = rst;
    @(posedge clk);
    #1;
    obs = {o_press, o_release, o_long, o_repeat, o_double, o_held};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic quiet(input int n, input logic btn, input logic [5:0] exp,
                       input string tag);
    for (int i = 0; i < n; i++) tick(btn, 1'b0, exp, tag);
  endtask

  initial begin
    i_rst = 1'b1;
    i_btn = 1'b0;

    // Reset, including a button held during reset.
    tick(1'b0, 1'b1, E_NONE, "reset_idle");
    tick(1'b1, 1'b1, E_NONE, "reset_btn_active");
    quiet(2, 1'b0, E_NONE, "post_reset_idle");

    // Short press: 3 active edges then release.
    tick(1'b1, 1'b0, E_PRESS, "short_press");
    quiet(2, 1'b1, E_HELD, "short_held");
    tick(1'b0, 1'b0, E_REL, "short_release");
    quiet(8, 1'b0, E_NONE, "short_after");

    // Long hold: 20 active edges, release lands on a repeat boundary.
    tick(1'b1, 1'b0, E_PRESS, "long_press");
    quiet(7, 1'b1, E_HELD, "long_pre");
    tick(1'b1, 1'b0, E_LONG, "long_event");
    quiet(3, 1'b1, E_HELD, "long_gap1");
    tick(1'b1, 1'b0, E_REP, "repeat_1");
    quiet(3, 1'b1, E_HELD, "long_gap2");
    tick(1'b1, 1'b0, E_REP, "repeat_2");
    quiet(3, 1'b1, E_HELD, "long_gap3");
    tick(1'b0, 1'b0, E_REL, "long_release_no_repeat");
    quiet(3, 1'b0, E_NONE, "long_after");

    // Double click: second press 3 edges after release.
    tick(1'b1, 1'b0, E_PRESS, "dc_press1");
    tick(1'b1, 1'b0, E_HELD, "dc_held1");
    tick(1'b0, 1'b0, E_REL, "dc_release1");
    quiet(2, 1'b0, E_NONE, "dc_gap");
    tick(1'b1, 1'b0, E_DBL, "dc_press2");
    tick(1'b0, 1'b0, E_REL, "dc_release2");
    // Third press: the double flag returned us to IDLE, so a plain press.
    tick(1'b1, 1'b0, E_PRESS, "dc_press3_plain");
    tick(1'b0, 1'b0, E_REL, "dc_release3");
    quiet(8, 1'b0, E_NONE, "dc_after");

    // Window edge: second press at release+6 still qualifies.
    tick(1'b1, 1'b0, E_PRESS, "win_in_press1");
    tick(1'b1, 1'b0, E_HELD, "win_in_held");
    tick(1'b0, 1'b0, E_REL, "win_in_release");
    quiet(5, 1'b0, E_NONE, "win_in_gap");
    tick(1'b1, 1'b0, E_DBL, "win_last_edge_double");
    tick(1'b0, 1'b0, E_REL, "win_in_release2");
    quiet(8, 1'b0, E_NONE, "win_in_after");

    // Window expired: second press at release+7 is a plain press.
    tick(1'b1, 1'b0, E_PRESS, "win_out_press1");
    tick(1'b1, 1'b0, E_HELD, "win_out_held");
    tick(1'b0, 1'b0, E_REL, "win_out_release");
    quiet(6, 1'b0, E_NONE, "win_out_gap");
    tick(1'b1, 1'b0, E_PRESS, "win_expired_plain");
    tick(1'b0, 1'b0, E_REL, "win_out_release2");
    quiet(8, 1'b0, E_NONE, "win_out_after");

    // Long press never arms the double-click window.
    tick(1'b1, 1'b0, E_PRESS, "lq_press");
    quiet(7, 1'b1, E_HELD, "lq_pre");
    tick(1'b1, 1'b0, E_LONG, "lq_long");
    tick(1'b1, 1'b0, E_HELD, "lq_held");
    tick(1'b0, 1'b0, E_REL, "lq_release");
    tick(1'b0, 1'b0, E_NONE, "lq_idle");
    tick(1'b1, 1'b0, E_PRESS, "lq_quick_press_plain");
    tick(1'b0, 1'b0, E_REL, "lq_quick_release");
    quiet(8, 1'b0, E_NONE, "lq_after");

    // Reset mid-hold with the button still active.
    tick(1'b1, 1'b0, E_PRESS, "rst_press");
    quiet(7, 1'b1, E_HELD, "rst_pre");
    tick(1'b1, 1'b0, E_LONG, "rst_long");
    tick(1'b1, 1'b0, E_HELD, "rst_held");
    tick(1'b1, 1'b1, E_NONE, "rst_mid_hold");
    tick(1'b1, 1'b0, E_PRESS, "rst_fresh_press");
    quiet(7, 1'b1, E_HELD, "rst_fresh_pre");
    tick(1'b1, 1'b0, E_LONG, "rst_fresh_long");
    tick(1'b0, 1'b0, E_REL, "rst_fresh_release");
    quiet(3, 1'b0, E_NONE, "rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
